// File: rtl/gate_vector_checker.sv
// Drives all four {a,b} vectors into the NOR-built all-gates block, waits a settle
// interval for each, then compares its six outputs against the golden truth table.
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_not,
  input  logic       y_nand,
  input  logic       y_xor,
  input  logic       y_xnor,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [5:0] golden;
  logic [5:0] observed;
  logic [5:0] mismatch;
  logic [2:0] mis_cnt;
  logic [4:0] err_next;

  // Golden values come from the registered a/b, which hold the vector under test.
  always_comb begin
    golden   = {a & b, a | b, ~a, ~(a & b), a ^ b, ~(a ^ b)};
    observed = {y_and, y_or, y_not, y_nand, y_xor, y_xnor};
    mismatch = golden ^ observed;
    mis_cnt  = '0;
    for (int i = 0; i < 6; i++) begin
      mis_cnt = mis_cnt + {2'b00, mismatch[i]};
    end
    err_next = err_count + {2'b00, mis_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            {a, b}    <= 2'b00;
            idx       <= '0;
            cnt       <= CNT_RELOAD;
            err_count <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          err_count      <= err_next;
          fail_mask[idx] <= |mismatch;
          if (idx == 2'd3) begin
            // Verdict is known here, so pass is already valid alongside the done pulse.
            pass  <= (err_next == 5'd0);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt    <= CNT_RELOAD;
            state  <= SETTLE;
          end
        end
        DONE: begin
          pass  <= (err_count == 5'd0) && !fail_mask[3];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized fault-injection bench: a NOR-built gate model with per-vector output flips,
// expectations pushed at stimulus time and checked by an independent monitor.
module tb_gate_vector_checker;

  localparam int S  = 4;
  localparam int S1 = 1;

  typedef struct {
    int         errs;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       a, b, busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] fail_mask;
  logic       a1, b1, busy1, done1, pass1;
  logic [4:0] err_count1;
  logic [3:0] fail_mask1;

  logic [5:0] flip [4];
  logic [5:0] y, y1;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc++;

  function automatic logic nor2(input logic x, input logic z);
    return ~(x | z);
  endfunction

  // All-gates block built only from NOR, outputs ordered {and,or,not,nand,xor,xnor}.
  function automatic logic [5:0] nor_gates(input logic ga, input logic gb);
    logic g_and, g_or, g_not, t, u, v, g_xnor;
    g_not  = nor2(ga, ga);
    g_and  = nor2(g_not, nor2(gb, gb));
    g_or   = nor2(nor2(ga, gb), nor2(ga, gb));
    t      = nor2(ga, gb);
    u      = nor2(ga, t);
    v      = nor2(gb, t);
    g_xnor = nor2(u, v);
    return {g_and, g_or, g_not, nor2(g_and, g_and), nor2(g_xnor, g_xnor), g_xnor};
  endfunction

  assign y  = nor_gates(a, b) ^ flip[{a, b}];
  assign y1 = nor_gates(a1, b1);

  gate_vector_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_and(y[5]), .y_or(y[4]), .y_not(y[3]), .y_nand(y[2]), .y_xor(y[1]), .y_xnor(y[0]),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  gate_vector_checker #(.SETTLE_CYCLES(S1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .y_and(y1[5]), .y_or(y1[4]), .y_not(y1[3]), .y_nand(y1[2]), .y_xor(y1[1]), .y_xnor(y1[0]),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .fail_mask(fail_mask1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: tracks the vector sequence and scores every completed run.
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  int   e0 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_q = 1'b0;
      done_q = 1'b0;
    end else begin
      if (busy && !busy_q) e0 = cyc;
      if (busy && !done && (cyc - e0) < 4 * (S + 1))
        chk("ab_seq", {30'd0, a, b}, (cyc - e0) / (S + 1));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", exp_q.size(), 1);
        end else begin
          chk("done_time", cyc - e0, 4 * (S + 1));
          chk("err_count", err_count, exp_q[0].errs);
          chk("fail_mask", fail_mask, exp_q[0].mask);
          chk("busy_in_done", busy, 1);
        end
      end
      if (done_q && exp_q.size() != 0) begin
        chk("pass", pass, exp_q[0].pass);
        chk("err_hold", err_count, exp_q[0].errs);
        chk("mask_hold", fail_mask, exp_q[0].mask);
        chk("busy_after_done", busy, 0);
        void'(exp_q.pop_front());
      end
      busy_q = busy;
      done_q = done;
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run(input logic [5:0] f0, input logic [5:0] f1,
                     input logic [5:0] f2, input logic [5:0] f3);
    exp_t e;
    flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
    e.errs = 0;
    for (int k = 0; k < 4; k++) begin
      e.errs   += $countones(flip[k]);
      e.mask[k] = |flip[k];
    end
    e.pass = (e.errs == 0);
    exp_q.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ab"}, {30'd0, a, b}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_mask"}, fail_mask, 0);
  endtask

  initial begin
    logic [5:0] f [4];
    int done_cnt, done_t;
    for (int k = 0; k < 4; k++) flip[k] = 6'd0;

    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(6'h00, 6'h00, 6'h00, 6'h00);
    run(6'h00, 6'h02, 6'h02, 6'h00);
    run(6'h3F, 6'h3F, 6'h3F, 6'h3F);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 4; k++)
        f[k] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      run(f[0], f[1], f[2], f[3]);
    end
    run(6'h00, 6'h00, 6'h00, 6'h00);

    // Reset in the middle of the second vector's settle interval.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrun_reset");
    @(negedge clk) rst_n = 1'b1;
    run(6'h00, 6'h00, 6'h00, 6'h00);

    // S=1 instance: stray starts mid-run and in the DONE cycle must be ignored.
    done_cnt = 0;
    done_t   = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done1) begin
        done_cnt++;
        done_t = t;
      end
      if (t >= 1 && t <= 8) chk("s1_ab_seq", {30'd0, a1, b1}, (t - 1) / 2);
      start1 = (t == 0 || t == 3 || t == 9);
    end
    chk("s1_done_count", done_cnt, 1);
    chk("s1_done_time", done_t, 9);
    chk("s1_pass", pass1, 1);
    chk("s1_err", err_count1, 0);
    chk("s1_busy", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
